// File: rtl/imem_program_loader_if.sv
// rtl/imem_program_loader_if.sv - byte stream input and instruction-memory write bus
interface imem_program_loader_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [15:0] imem_addr;
  logic [15:0] imem_wdata;

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_program_loader.sv
// rtl/imem_program_loader.sv - framed byte-stream loader filling instruction memory, gating CPU reset
module imem_program_loader #(
  parameter int          DEPTH_W   = 8,
  parameter logic [15:0] BASE_ADDR = 16'h0,
  parameter int          TIMEOUT   = 1024,
  parameter logic [7:0]  HDR       = 8'hA5
) (
  input  logic                 clk,
  input  logic                 pc_reset,
  imem_program_loader_if.slave bus,
  output logic                 cpu_hold,
  output logic                 load_done,
  output logic                 load_error,
  output logic [15:0]          words_loaded
);
  localparam int          TW  = $clog2(TIMEOUT + 1);
  localparam logic [16:0] CAP = 17'(2 ** DEPTH_W);

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK
  } state_t;

  state_t        state, state_next;
  logic [15:0]   len, idx;
  logic [7:0]    hi, lo, chk;
  logic [TW-1:0] tmo;
  logic [15:0]   n_next;
  logic          accept, too_big, last_word, tmo_hit;

  assign accept         = bus.in_valid & bus.in_ready;
  assign bus.in_ready   = (state != WRITE);
  assign bus.imem_we    = (state == WRITE);
  assign bus.imem_addr  = BASE_ADDR + idx;
  assign bus.imem_wdata = {hi, lo};
  assign n_next         = {len[15:8], bus.in_data};
  assign too_big        = ({1'b0, n_next} > CAP);
  assign last_word      = ((idx + 16'd1) == len);
  // An accepted byte in the limit cycle suppresses the abort.
  assign tmo_hit        = (state != IDLE) && !accept && (tmo == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && bus.in_data == HDR) state_next = LEN_HI;
      LEN_HI:  if (accept) state_next = LEN_LO;
      LEN_LO:  if (accept) begin
                 if (too_big)            state_next = IDLE;
                 else if (n_next == '0)  state_next = CHECK;
                 else                    state_next = DATA_HI;
               end
      DATA_HI: if (accept) state_next = DATA_LO;
      DATA_LO: if (accept) state_next = WRITE;
      WRITE:   state_next = last_word ? CHECK : DATA_HI;
      CHECK:   if (accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (tmo_hit) state_next = IDLE;
  end

  always_ff @(posedge clk or posedge pc_reset) begin
    if (pc_reset) begin
      len          <= '0;
      idx          <= '0;
      hi           <= '0;
      lo           <= '0;
      chk          <= '0;
      tmo          <= '0;
      cpu_hold     <= 1'b1;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= '0;
    end else begin
      load_done <= 1'b0;
      tmo       <= (state == IDLE || accept) ? '0 : tmo + 1'b1;
      case (state)
        IDLE: if (accept && bus.in_data == HDR) begin
          cpu_hold     <= 1'b1;
          load_error   <= 1'b0;
          words_loaded <= '0;
          chk          <= '0;
          idx          <= '0;
        end
        LEN_HI: if (accept) begin
          len[15:8] <= bus.in_data;
          chk       <= chk ^ bus.in_data;
        end
        LEN_LO: if (accept) begin
          len[7:0] <= bus.in_data;
          chk      <= chk ^ bus.in_data;
          if (too_big) load_error <= 1'b1;
        end
        DATA_HI: if (accept) begin
          hi  <= bus.in_data;
          chk <= chk ^ bus.in_data;
        end
        DATA_LO: if (accept) begin
          lo  <= bus.in_data;
          chk <= chk ^ bus.in_data;
        end
        WRITE: begin
          words_loaded <= words_loaded + 16'd1;
          // Hold idx on the last word so the address never runs past N-1.
          if (!last_word) idx <= idx + 16'd1;
        end
        CHECK: if (accept) begin
          if (bus.in_data == chk) begin
            load_done <= 1'b1;
            cpu_hold  <= 1'b0;
          end else begin
            load_error <= 1'b1;
          end
        end
        default: ;
      endcase
      if (tmo_hit) load_error <= 1'b1;
    end
  end
endmodule
